// File: rtl/spike_pkg.sv
// Shared types, widths and the round-robin channel picker for the spike burst generator.
package spike_pkg;

    localparam int unsigned CH_W  = 4;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned HO_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP,
        ST_HOLDOFF,
        ST_DONE
    } state_e;

    // Isolate the lowest set bit of a channel vector.
    function automatic logic [CH_W-1:0] lowest_bit(input logic [CH_W-1:0] x);
        return x & (~x + CH_W'(1));
    endfunction

    // Next set channel strictly above cur, wrapping; cur=0 yields the lowest set channel.
    function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] mask,
                                                input logic [CH_W-1:0] cur);
        logic [CH_W-1:0] upto;
        logic [CH_W-1:0] above;
        upto  = (cur << 1) - CH_W'(1);
        above = mask & ~upto;
        return (above != '0) ? lowest_bit(above) : lowest_bit(mask);
    endfunction

endpackage

// File: rtl/spike_gap_timer.sv
// Loadable down-counter shared by the inter-pulse gap and the post-burst holdoff.
module spike_gap_timer
    import spike_pkg::*;
(
    input  logic            i_clk_tst,
    input  logic            w_rst_n,
    input  logic            load,
    input  logic [HO_W-1:0] val,
    output logic [HO_W-1:0] value,
    output logic            expire_c
);

    logic [HO_W-1:0] cnt_q;

    always_ff @(posedge i_clk_tst or negedge w_rst_n) begin
        if (!w_rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - HO_W'(1);
        end
    end

    assign value    = cnt_q;
    assign expire_c = (cnt_q == HO_W'(1));

endmodule

// File: rtl/spike_burst_gen.sv
// Spike burst generator: P_SPIKE_NOM one-cycle pulses spaced by P_GAP, then a P_HOLDOFF quiet
// period and a done pulse. Define SPIKE_GEN_ROUND_ROBIN_EN to drive one channel per pulse.
module spike_burst_gen
    import spike_pkg::*;
#(
    parameter int unsigned P_SPIKE_NOM = 4,
    parameter int unsigned P_GAP       = 2,
    parameter int unsigned P_HOLDOFF   = 8'hF5
) (
    input  logic          i_clk_tst,
    input  logic          w_rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [CH_W:1] i_chan_mask,
    output logic [CH_W:1] o_spike,
    output logic          o_busy,
    output logic          o_done
);

    state_e           state_q;
    state_e           state_d;
    logic [CH_W:1]    mask_q;
    logic [CNT_W-1:0] spk_cnt_q;
    logic [CH_W-1:0]  pat_c;
    logic [CH_W-1:0]  first_pat_c;
    logic [CH_W-1:0]  next_pat_c;
    logic             last_pulse_c;
    logic             tmr_load_c;
    logic [HO_W-1:0]  tmr_val_c;
    logic [HO_W-1:0]  tmr_value;
    logic             tmr_expire_c;

    spike_gap_timer u_timer (
        .i_clk_tst (i_clk_tst),
        .w_rst_n   (w_rst_n),
        .load      (tmr_load_c),
        .val       (tmr_val_c),
        .value     (tmr_value),
        .expire_c  (tmr_expire_c)
    );

`ifdef SPIKE_GEN_ROUND_ROBIN_EN
    logic [CH_W-1:0] sel_q;

    assign first_pat_c = rr_next(i_chan_mask, '0);
    assign next_pat_c  = rr_next(mask_q, sel_q);

    always_ff @(posedge i_clk_tst or negedge w_rst_n) begin
        if (!w_rst_n) begin
            sel_q <= '0;
        end else if (state_d == ST_PULSE) begin
            sel_q <= pat_c;
        end
    end
`else
    assign first_pat_c = i_chan_mask;
    assign next_pat_c  = mask_q;
`endif

    assign last_pulse_c = ((spk_cnt_q + CNT_W'(1)) == CNT_W'(P_SPIKE_NOM));

    // Next state, timer load and the pattern the output register takes on entering PULSE.
    always_comb begin
        state_d    = state_q;
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;
        pat_c      = '0;
        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_abort && (i_chan_mask != '0)) begin
                    state_d = ST_PULSE;
                    pat_c   = first_pat_c;
                end
            end
            ST_PULSE: begin
                if (last_pulse_c) begin
                    state_d    = ST_HOLDOFF;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = HO_W'(P_HOLDOFF);
                end else if (P_GAP == 0) begin
                    state_d = ST_PULSE;
                    pat_c   = next_pat_c;
                end else begin
                    state_d    = ST_GAP;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = HO_W'(P_GAP);
                end
            end
            // A zero timer also exits, so a stale count can never wedge the FSM.
            ST_GAP: begin
                if (tmr_expire_c || (tmr_value == '0)) begin
                    state_d = ST_PULSE;
                    pat_c   = next_pat_c;
                end
            end
            ST_HOLDOFF: begin
                if (tmr_expire_c || (tmr_value == '0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if ((state_q != ST_IDLE) && i_abort) begin
            state_d    = ST_IDLE;
            pat_c      = '0;
            tmr_load_c = 1'b1;
            tmr_val_c  = '0;
        end
    end

    // State, burst bookkeeping and outputs registered from the next state.
    always_ff @(posedge i_clk_tst or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            spk_cnt_q <= '0;
            o_spike   <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state_q <= state_d;
            o_spike <= pat_c;
            o_busy  <= (state_d != ST_IDLE);
            o_done  <= (state_d == ST_DONE);
            if ((state_q == ST_IDLE) && (state_d == ST_PULSE)) begin
                mask_q    <= i_chan_mask;
                spk_cnt_q <= '0;
            end else if (state_q == ST_PULSE) begin
                spk_cnt_q <= spk_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spike_burst_gen.sv
// Bench for spike_burst_gen: directed scenarios plus random traffic against a burst-schedule model.
module tb_spike_burst_gen;

    logic       i_clk_tst = 1'b0;
    logic       w_rst_n;
    logic       i_start;
    logic       i_abort;
    logic [4:1] i_chan_mask;
    logic [4:1] spk_a, spk_b;
    logic       busy_a, busy_b, done_a, done_b;

    always #5 i_clk_tst = ~i_clk_tst;

    spike_burst_gen dut_a (
        .i_clk_tst   (i_clk_tst),
        .w_rst_n     (w_rst_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_chan_mask (i_chan_mask),
        .o_spike     (spk_a),
        .o_busy      (busy_a),
        .o_done      (done_a)
    );

    spike_burst_gen #(.P_SPIKE_NOM(7), .P_GAP(0), .P_HOLDOFF(1)) dut_b (
        .i_clk_tst   (i_clk_tst),
        .w_rst_n     (w_rst_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_chan_mask (i_chan_mask),
        .o_spike     (spk_b),
        .o_busy      (busy_b),
        .o_done      (done_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model: a burst is a start time, a mask and per-instance schedule parameters.
    int         m_n [2] = '{4, 7};
    int         m_g [2] = '{2, 0};
    int         m_h [2] = '{245, 1};
    bit         m_act  [2];
    int         m_t0   [2];
    logic [3:0] m_mask [2];

    function automatic int done_off(input int d);
        return (m_n[d] - 1) * (m_g[d] + 1) + m_h[d] + 1;
    endfunction

    function automatic logic [3:0] pick(input logic [3:0] mask, input int k);
`ifdef SPIKE_GEN_ROUND_ROBIN_EN
        logic [3:0] ch[$];
        logic [3:0] one;
        one = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            if ((mask & one) != 4'b0000) ch.push_back(one);
            one = one << 1;
        end
        return ch[k % ch.size()];
`else
        if (k < 0) return 4'b0000;
        return mask;
`endif
    endfunction

    function automatic logic [5:0] expect_out(input int d);
        int         off;
        int         slot;
        logic [3:0] sp;
        if (!m_act[d]) return 6'b0;
        off  = cyc - m_t0[d];
        slot = m_g[d] + 1;
        sp   = 4'b0000;
        if ((off % slot == 0) && (off / slot < m_n[d])) sp = pick(m_mask[d], off / slot);
        return {sp, 1'b1, (off == done_off(d))};
    endfunction

    task automatic model_edge(input logic st, input logic ab, input logic [3:0] m, input logic rs);
        for (int d = 0; d < 2; d++) begin
            if (!rs) begin
                m_act[d] = 1'b0;
            end else if (m_act[d]) begin
                if (ab || (cyc - m_t0[d] == done_off(d))) m_act[d] = 1'b0;
            end else if (st && !ab && (m != 4'b0000)) begin
                m_act[d]  = 1'b1;
                m_t0[d]   = cyc + 1;
                m_mask[d] = m;
            end
        end
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic compare_all();
        logic [5:0] ea, eb;
        ea = expect_out(0);
        eb = expect_out(1);
        chk("a_spike", spk_a, ea[5:2]);
        chk("a_busy", {3'b0, busy_a}, {3'b0, ea[1]});
        chk("a_done", {3'b0, done_a}, {3'b0, ea[0]});
        chk("b_spike", spk_b, eb[5:2]);
        chk("b_busy", {3'b0, busy_b}, {3'b0, eb[1]});
        chk("b_done", {3'b0, done_b}, {3'b0, eb[0]});
    endtask

    // Drive inputs for the coming edge, then sample at the falling edge.
    task automatic step(input logic st, input logic ab, input logic [3:0] m, input logic rs);
        i_start     = st;
        i_abort     = ab;
        i_chan_mask = m;
        w_rst_n     = rs;
        if (!rs) begin
            #1;
            chk("async_rst_a", {busy_a, done_a, |spk_a, 1'b0}, 4'b0000);
            chk("async_rst_b", {busy_b, done_b, |spk_b, 1'b0}, 4'b0000);
        end
        @(posedge i_clk_tst);
        model_edge(st, ab, m, rs);
        @(negedge i_clk_tst);
        compare_all();
    endtask

    initial begin
        logic [3:0] dm;
        logic [3:0] dir_pat [4];
        logic       seen_done;
        int         k;

`ifdef SPIKE_GEN_ROUND_ROBIN_EN
        dm      = 4'b1011;
        dir_pat = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
`else
        dm      = 4'b0101;
        dir_pat = '{4'b0101, 4'b0101, 4'b0101, 4'b0101};
`endif

        // Reset and idle
        i_start = 1'b0; i_abort = 1'b0; i_chan_mask = 4'b0000; w_rst_n = 1'b0;
        #1;
        chk("reset_state", {busy_a, done_a, |spk_a, busy_b}, 4'b0000);
        step(1'b0, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 4'b0000, 1'b1);

        // Full burst started in cycle 0
        step(1'b1, 1'b0, dm, 1'b1);
        k = 0;
        for (int t = 1; t <= 258; t++) begin
            if (t == 1 || t == 4 || t == 7 || t == 10) begin
                chk("dir_spike", spk_a, dir_pat[k]);
                k++;
            end
            if (t == 2) chk("dir_gap", spk_a, 4'b0000);
            if (t == 255) chk("dir_pre_done", {3'b0, done_a}, 4'd0);
            if (t == 256) chk("dir_done", {2'b0, busy_a, done_a}, 4'b0011);
            if (t == 257) chk("dir_idle", {2'b0, busy_a, done_a}, 4'b0000);
            step((t == 20), 1'b0, 4'b1111, 1'b1);
        end

        // Zero mask start and abort+start in IDLE are both ignored
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        chk("zero_mask", {3'b0, busy_a}, 4'd0);
        step(1'b1, 1'b1, 4'b1111, 1'b1);
        chk("abort_start_idle", {3'b0, busy_a}, 4'd0);
        step(1'b0, 1'b0, 4'b0000, 1'b1);

        // Abort sampled in cycle 5 of a burst
        step(1'b1, 1'b0, 4'b0011, 1'b1);
        for (int t = 1; t <= 4; t++) step(1'b0, 1'b0, 4'b0011, 1'b1);
        chk("pre_abort_busy", {3'b0, busy_a}, 4'd1);
        step(1'b0, 1'b1, 4'b0011, 1'b1);
        chk("abort_spike", spk_a, 4'b0000);
        chk("abort_busy", {3'b0, busy_a}, 4'd0);
        seen_done = 1'b0;
        for (int t = 0; t < 260; t++) begin
            step(1'b0, 1'b0, 4'b0011, 1'b1);
            seen_done = seen_done | done_a;
        end
        chk("abort_no_done", {3'b0, seen_done}, 4'd0);

        // Reset mid-burst, fresh start afterwards
        step(1'b1, 1'b0, 4'b0110, 1'b1);
        step(1'b0, 1'b0, 4'b0110, 1'b1);
        step(1'b0, 1'b0, 4'b0110, 1'b0);
        step(1'b0, 1'b0, 4'b0110, 1'b0);
        step(1'b0, 1'b0, 4'b0110, 1'b1);
        chk("rst_release_idle", {3'b0, busy_a}, 4'd0);
        step(1'b0, 1'b0, 4'b0110, 1'b1);
        step(1'b1, 1'b0, 4'b0110, 1'b1);
`ifdef SPIKE_GEN_ROUND_ROBIN_EN
        chk("rst_restart", spk_a, 4'b0010);
`else
        chk("rst_restart", spk_a, 4'b0110);
`endif
        for (int t = 0; t < 260; t++) step(1'b0, 1'b0, 4'b0000, 1'b1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 299) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
